uart_rx_param: RTL

Parametrised, oversampling UART receiver. It is the next-generation rx for the UART datapath. It adds configurable word width, 1 or 2 stop bits, and runtime-selectable parity (none/even/odd). It also adds an input synchroniser, 3-sample majority voting, false-start rejection, per-frame parity and framing error flags, break detection, and line-idle recovery. It sits between the baud-rate generator (which supplies the i_rate strobe) and the UART interface/FIFO logic (which consumes o_data_out on o_rx_done).

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sampler.sv | 47 ++++
 rtl/uart_rx_param.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the rx and the planned tx.
//   - one-hot receiver state encoding
//   - parity mode codes (PAR_NONE, PAR_EVEN, PAR_ODD; code 3 also means none)
//   - default frame-format constants
//   - par_enabled(): true when the mode code selects even or odd parity
package uart_pkg;

  localparam int unsigned DEF_WIDTH_WORD    = 8;
  localparam int unsigned DEF_CANT_BIT_STOP = 2;
  localparam int unsigned DEF_OVERSAMPLE    = 16;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } par_mode_e;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_START   = 6'b000010,
    ST_DATA    = 6'b000100,
    ST_PARITY  = 6'b001000,
    ST_STOP    = 6'b010000,
    ST_RECOVER = 6'b100000
  } rx_state_e;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for the UART receiver.
//   clk, rst   : system clock, asynchronous active-high reset
//   rate       : oversample tick strobe
//   bit_rx     : raw asynchronous serial line
//   line_sync  : line after a 2-flop synchroniser (resets to idle/1)
//   vote       : majority of the current synchronised sample and the
//                samples taken on the two previous ticks
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rate,
  input  logic bit_rx,
  output logic line_sync,
  output logic vote
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;

  always_comb begin
    sync1_d = bit_rx;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    if (rate) begin
      hist_d = {hist_q[0], sync2_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // On the decision tick hist_q holds the two preceding ticks' samples.
  assign line_sync = sync2_q;
  assign vote      = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) |
                     (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
//   i_clock, i_reset : system clock, asynchronous active-high reset
//   i_rate           : one-cycle strobe at OVERSAMPLE x baud
//   i_bit_rx         : asynchronous serial line, idles high
//   i_parity_mode    : 0/3 none, 1 even, 2 odd (latched per frame)
//   o_rx_done        : one-cycle pulse per completed frame
//   o_data_out       : last received word
//   o_parity_err     : parity error of the last frame
//   o_frame_err      : framing error of the last frame
//   o_break          : one-cycle pulse on a break condition
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_WORD    = DEF_WIDTH_WORD,
  parameter int unsigned CANT_BIT_STOP = DEF_CANT_BIT_STOP,
  parameter int unsigned OVERSAMPLE    = DEF_OVERSAMPLE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rate,
  input  logic                  i_bit_rx,
  input  logic [1:0]            i_parity_mode,
  output logic                  o_rx_done,
  output logic [WIDTH_WORD-1:0] o_data_out,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(WIDTH_WORD + 1);
  localparam logic [TICK_W-1:0] DEC_TICK  = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_CNT  = BIT_W'(WIDTH_WORD);
  localparam logic              LAST_STOP = 1'(CANT_BIT_STOP - 1);

  logic line_sync;
  logic vote;

  uart_rx_sampler u_sampler (
    .clk       (i_clock),
    .rst       (i_reset),
    .rate      (i_rate),
    .bit_rx    (i_bit_rx),
    .line_sync (line_sync),
    .vote      (vote)
  );

  rx_state_e             state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [TICK_W-1:0]     rec_cnt_q, rec_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [WIDTH_WORD-1:0] shift_q, shift_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_err_q, par_err_d;
  logic                  done_q, done_d;
  logic [WIDTH_WORD-1:0] data_out_q, data_out_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ferr_out_q, ferr_out_d;
  logic                  brk_q, brk_d;

  logic              at_dec;
  logic              at_last;
  logic [TICK_W-1:0] tick_inc;
  logic              par_on;
  logic              par_expect;

  always_comb begin
    at_dec     = (tick_q == DEC_TICK);
    at_last    = (tick_q == LAST_TICK);
    tick_inc   = at_last ? '0 : tick_q + TICK_W'(1);
    par_on     = par_enabled(par_mode_q);
    par_expect = (^shift_q) ^ (par_mode_q == PAR_ODD);

    state_d    = state_q;
    tick_d     = tick_q;
    rec_cnt_d  = rec_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    brk_d      = 1'b0;

    if (i_rate) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!line_sync) begin
            state_d = ST_START;
            tick_d  = TICK_W'(1);
          end
        end

        ST_START: begin
          tick_d = tick_inc;
          if (at_dec) begin
            if (vote) begin
              state_d = ST_IDLE;
              tick_d  = '0;
            end else begin
              par_mode_d = i_parity_mode;
            end
          end else if (at_last) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_bit_d = 1'b0;
            par_err_d = 1'b0;
          end
        end

        ST_DATA: begin
          tick_d = tick_inc;
          if (at_dec) begin
            shift_d   = {vote, shift_q[WIDTH_WORD-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (at_last && (bit_cnt_q == LAST_CNT)) begin
            state_d    = par_on ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end
        end

        ST_PARITY: begin
          tick_d = tick_inc;
          if (at_dec) begin
            par_bit_d = vote;
            par_err_d = (vote != par_expect);
          end else if (at_last) begin
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          tick_d = tick_inc;
          if (at_dec) begin
            if (!vote) begin
              // Frame ends on the first bad stop bit; remaining stops skipped.
              done_d     = 1'b1;
              data_out_d = shift_q;
              perr_out_d = par_on & par_err_q;
              ferr_out_d = 1'b1;
              brk_d      = (shift_q == '0) && (!par_on || !par_bit_q);
              state_d    = ST_RECOVER;
              rec_cnt_d  = '0;
              tick_d     = '0;
            end else if (stop_idx_q == LAST_STOP) begin
              // Leaving mid-bit lets the next start edge arrive early.
              done_d     = 1'b1;
              data_out_d = shift_q;
              perr_out_d = par_on & par_err_q;
              ferr_out_d = 1'b0;
              state_d    = ST_IDLE;
              tick_d     = '0;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end

        ST_RECOVER: begin
          if (!line_sync) begin
            rec_cnt_d = '0;
          end else if (rec_cnt_q == LAST_TICK) begin
            rec_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            rec_cnt_d = rec_cnt_q + TICK_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      rec_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_mode_q <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      rec_cnt_q  <= rec_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_q      <= brk_d;
    end
  end

  assign o_rx_done    = done_q;
  assign o_data_out   = data_out_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_break      = brk_q;

endmodule
